// File: rtl/calc_op_sequencer.sv
// calc_op_sequencer
// Multi-cycle sign-magnitude arithmetic sequencer for the keypad calculator.
// A start pulse latches two sign-magnitude operands and an operator code.
// The block then runs add/sub in one pass, multiply by LSB-first shift-add,
// or divide by MSB-first restoring division, and pulses done with the result.
//
// Optional feature: define CALC_SEQ_DIV_EN to build the divider and the
// remainder output. Without it, op 011 is invalid and remainder is tied to 0.
//
// Ports:
//   clk, reset_n       clock, asynchronous active-low reset
//   start, clear       request pulse (ignored while busy), synchronous abort
//   op_a_mag/op_a_sign operand A (sign 1 = negative)
//   op_b_mag/op_b_sign operand B
//   operator           000 add, 001 sub, 010 mul, 011 div, others invalid
//   busy, done         operation in progress, one-cycle completion pulse
//   result_mag/_sign   signed result (quotient for divide), sign 0 on zero
//   remainder          divide remainder magnitude, 0 otherwise
//   error              divide by zero or invalid operator
module calc_op_sequencer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic                 clear,
    input  logic [WIDTH-1:0]     op_a_mag,
    input  logic                 op_a_sign,
    input  logic [WIDTH-1:0]     op_b_mag,
    input  logic                 op_b_sign,
    input  logic [2:0]           operator,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   result_mag,
    output logic                 result_sign,
    output logic [WIDTH-1:0]     remainder,
    output logic                 error
);
    localparam int unsigned CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_MUL = 3'b010;
`ifdef CALC_SEQ_DIV_EN
    localparam logic [2:0] OP_DIV = 3'b011;
`endif

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADDSUB,
        S_MUL
`ifdef CALC_SEQ_DIV_EN
        , S_DIV
`endif
    } state_t;

    state_t state, state_next, start_target;
    logic start_err;

    // a_reg: A magnitude for add/sub, dividend/quotient shift register for divide.
    // b_reg: B magnitude; shifted right as the multiplier during multiply.
    logic [WIDTH-1:0]   a_reg, b_reg;
    logic               a_sgn, b_sgn, err_mode;
    logic [2*WIDTH-1:0] mcand, acc, acc_next;
    logic [CW-1:0]      cnt;
    logic               last_iter;
    logic [WIDTH:0]     as_mag;
    logic               as_sign, mul_sign;
`ifdef CALC_SEQ_DIV_EN
    logic [WIDTH-1:0]   rem_reg, rem_next, q_next;
    logic [WIDTH:0]     div_shift;
    logic               div_ge, div_sign;
`endif

    // Operator decode at start; errors are finished through the ADDSUB pass.
    always_comb begin
        start_err    = 1'b1;
        start_target = S_ADDSUB;
        case (operator)
            OP_ADD, OP_SUB: start_err = 1'b0;
            OP_MUL: begin
                start_err    = 1'b0;
                start_target = S_MUL;
            end
`ifdef CALC_SEQ_DIV_EN
            OP_DIV: if (op_b_mag != '0) begin
                start_err    = 1'b0;
                start_target = S_DIV;
            end
`endif
            default: ;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_next;
    end

    // Next-state logic
    assign last_iter = (cnt == LAST);

    always_comb begin
        state_next = state;
        if (clear) begin
            state_next = S_IDLE;
        end else begin
            case (state)
                S_IDLE:   if (start) state_next = start_target;
                S_ADDSUB: state_next = S_IDLE;
                S_MUL:    if (last_iter) state_next = S_IDLE;
`ifdef CALC_SEQ_DIV_EN
                S_DIV:    if (last_iter) state_next = S_IDLE;
`endif
                default:  state_next = S_IDLE;
            endcase
        end
    end

    // Output logic
    always_comb begin
        busy = (state != S_IDLE);
    end

    // Sign-magnitude add/sub; b_sgn already carries the subtract inversion.
    always_comb begin
        as_mag  = '0;
        as_sign = 1'b0;
        if (a_sgn == b_sgn) begin
            as_mag  = {1'b0, a_reg} + {1'b0, b_reg};
            as_sign = a_sgn;
        end else if (a_reg > b_reg) begin
            as_mag  = {1'b0, a_reg - b_reg};
            as_sign = a_sgn;
        end else if (b_reg > a_reg) begin
            as_mag  = {1'b0, b_reg - a_reg};
            as_sign = b_sgn;
        end
        if (as_mag == '0) as_sign = 1'b0;
    end

    // One shift-add step: mcand holds A << cnt, b_reg holds B >> cnt.
    always_comb begin
        acc_next = acc + (b_reg[0] ? mcand : '0);
        mul_sign = (a_sgn ^ b_sgn) && (acc_next != '0);
    end

`ifdef CALC_SEQ_DIV_EN
    // One restoring-division step, next dividend bit shifted in from a_reg.
    always_comb begin
        div_shift = {rem_reg, a_reg[WIDTH-1]};
        div_ge    = (div_shift >= {1'b0, b_reg});
        rem_next  = div_ge ? WIDTH'(div_shift - {1'b0, b_reg}) : div_shift[WIDTH-1:0];
        q_next    = {a_reg[WIDTH-2:0], div_ge};
        div_sign  = (a_sgn ^ b_sgn) && (q_next != '0);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rem_reg   <= '0;
            remainder <= '0;
        end else if (clear) begin
            remainder <= '0;
        end else if (state == S_IDLE) begin
            if (start) rem_reg <= '0;
        end else if (state == S_DIV) begin
            rem_reg <= rem_next;
            if (last_iter) remainder <= rem_next;
        end else if (state == S_ADDSUB || last_iter) begin
            remainder <= '0;
        end
    end
`else
    assign remainder = '0;
`endif

    // Datapath and registered results
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_reg       <= '0;
            b_reg       <= '0;
            a_sgn       <= 1'b0;
            b_sgn       <= 1'b0;
            err_mode    <= 1'b0;
            mcand       <= '0;
            acc         <= '0;
            cnt         <= '0;
            done        <= 1'b0;
            result_mag  <= '0;
            result_sign <= 1'b0;
            error       <= 1'b0;
        end else begin
            done <= 1'b0;
            if (clear) begin
                result_mag  <= '0;
                result_sign <= 1'b0;
                error       <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: if (start) begin
                        a_reg    <= op_a_mag;
                        b_reg    <= op_b_mag;
                        a_sgn    <= op_a_sign;
                        b_sgn    <= op_b_sign ^ (operator == OP_SUB);
                        err_mode <= start_err;
                        mcand    <= (2*WIDTH)'(op_a_mag);
                        acc      <= '0;
                        cnt      <= '0;
                        error    <= 1'b0;
                    end
                    S_ADDSUB: begin
                        done        <= 1'b1;
                        result_mag  <= err_mode ? '0 : (2*WIDTH)'(as_mag);
                        result_sign <= err_mode ? 1'b0 : as_sign;
                        error       <= err_mode;
                    end
                    S_MUL: begin
                        acc   <= acc_next;
                        mcand <= mcand << 1;
                        b_reg <= b_reg >> 1;
                        cnt   <= cnt + CW'(1);
                        if (last_iter) begin
                            done        <= 1'b1;
                            result_mag  <= acc_next;
                            result_sign <= mul_sign;
                            error       <= 1'b0;
                        end
                    end
`ifdef CALC_SEQ_DIV_EN
                    S_DIV: begin
                        a_reg <= q_next;
                        cnt   <= cnt + CW'(1);
                        if (last_iter) begin
                            done        <= 1'b1;
                            result_mag  <= (2*WIDTH)'(q_next);
                            result_sign <= div_sign;
                            error       <= 1'b0;
                        end
                    end
`endif
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_calc_op_sequencer.sv
// tb_calc_op_sequencer
// Directed bench for calc_op_sequencer (WIDTH=8). Stimulus pushes the
// expected result into a scoreboard queue; a monitor pops and compares on
// every done pulse, including done latency measured from the start edge.
`timescale 1ns/1ps
module tb_calc_op_sequencer;
    localparam int unsigned W = 8;

    logic           clk = 1'b0;
    logic           reset_n, start, clear, a_sign, b_sign;
    logic [W-1:0]   a_mag, b_mag;
    logic [2:0]     op_code;
    logic           busy, done, result_sign, error;
    logic [2*W-1:0] result_mag;
    logic [W-1:0]   remainder;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    typedef struct {
        string          tag;
        logic [2*W-1:0] mag;
        logic           sign;
        logic [W-1:0]   rem;
        logic           err;
        int             lat;
        int             e0;
    } exp_t;

    exp_t sb[$];

    calc_op_sequencer #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .clear       (clear),
        .op_a_mag    (a_mag),
        .op_a_sign   (a_sign),
        .op_b_mag    (b_mag),
        .op_b_sign   (b_sign),
        .operator    (op_code),
        .busy        (busy),
        .done        (done),
        .result_mag  (result_mag),
        .result_sign (result_sign),
        .remainder   (remainder),
        .error       (error)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint got, input longint exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Monitor: compare every done pulse against the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (reset_n && done) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                e = sb.pop_front();
                check({e.tag, "_mag"},  result_mag,  e.mag);
                check({e.tag, "_sign"}, result_sign, e.sign);
                check({e.tag, "_rem"},  remainder,   e.rem);
                check({e.tag, "_err"},  error,       e.err);
                check({e.tag, "_lat"},  cyc - e.e0,  e.lat);
            end
        end
    end

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic issue(input string tag, input logic as, input logic [W-1:0] am,
                         input logic bs, input logic [W-1:0] bm, input logic [2:0] op,
                         input bit push, input logic [2*W-1:0] emag, input logic esign,
                         input logic [W-1:0] erem, input logic eerr, input int elat);
        exp_t e;
        a_sign = as; a_mag = am; b_sign = bs; b_mag = bm; op_code = op;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({tag, "_busy"}, busy, 1);
        if (push) begin
            e.tag = tag; e.mag = emag; e.sign = esign; e.rem = erem;
            e.err = eerr; e.lat = elat; e.e0 = cyc;
            sb.push_back(e);
        end
    endtask

    // Returns at the negedge of the done cycle, so the next issue is back-to-back.
    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (busy) check({tag, "_timeout"}, 1, 0);
    endtask

    initial begin
        reset_n = 1'b0; start = 1'b0; clear = 1'b0;
        a_sign = 1'b0; b_sign = 1'b0; a_mag = '0; b_mag = '0; op_code = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_mag", result_mag, 0);
        check("rst_sign", result_sign, 0);
        check("rst_rem", remainder, 0);
        check("rst_err", error, 0);
        reset_n = 1'b1;
        @(negedge clk);

        // Add/sub
        issue("add_25_m40", 0, 25, 1, 40, 3'b000, 1, 15, 1, 0, 0, 1);   wait_idle("add_25_m40");
        issue("sub_7_7",    0, 7,  0, 7,  3'b001, 1, 0,  0, 0, 0, 1);   wait_idle("sub_7_7");
        issue("sub_m5_3",   1, 5,  0, 3,  3'b001, 1, 8,  1, 0, 0, 1);   wait_idle("sub_m5_3");
        issue("add_max",    0, 255, 0, 255, 3'b000, 1, 510, 0, 0, 0, 1); wait_idle("add_max");
        issue("add_nmax",   1, 255, 1, 255, 3'b000, 1, 510, 1, 0, 0, 1); wait_idle("add_nmax");
        issue("add_negz",   1, 0,  1, 0,  3'b000, 1, 0,  0, 0, 0, 1);   wait_idle("add_negz");

        // Multiply
        issue("mul_m12_11", 1, 12, 0, 11, 3'b010, 1, 132, 1, 0, 0, 8);     wait_idle("mul_m12_11");
        issue("mul_255",    0, 255, 0, 255, 3'b010, 1, 65025, 0, 0, 0, 8); wait_idle("mul_255");
        issue("mul_zero",   0, 0,  1, 5,  3'b010, 1, 0,   0, 0, 0, 8);     wait_idle("mul_zero");

        // Divide and errors
`ifdef CALC_SEQ_DIV_EN
        issue("div_200_m7", 0, 200, 1, 7, 3'b011, 1, 28, 1, 4, 0, 8);
`else
        issue("div_200_m7", 0, 200, 1, 7, 3'b011, 1, 0, 0, 0, 1, 1);
`endif
        wait_idle("div_200_m7");
        issue("div_by0",    0, 5,  0, 0,  3'b011, 1, 0,  0, 0, 1, 1);   wait_idle("div_by0");
        issue("op_inval",   0, 5,  0, 3,  3'b101, 1, 0,  0, 0, 1, 1);   wait_idle("op_inval");

        // start mid-multiply is ignored
        issue("mul_ign", 1, 12, 0, 11, 3'b010, 1, 132, 1, 0, 0, 8);
        repeat (2) @(negedge clk);
        a_sign = 0; a_mag = 1; b_sign = 0; b_mag = 1; op_code = 3'b000; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle("mul_ign");

        // Back-to-back: second start lands in the done cycle of the first
        issue("b2b_mul", 0, 3, 0, 4, 3'b010, 1, 12, 0, 0, 0, 8); wait_idle("b2b_mul");
        issue("b2b_add", 0, 1, 0, 2, 3'b000, 1, 3,  0, 0, 0, 1); wait_idle("b2b_add");

        // clear in the 4th multiply cycle
        issue("clr_mul", 0, 9, 0, 9, 3'b010, 0, 0, 0, 0, 0, 0);
        repeat (3) @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        check("clr_busy", busy, 0);
        check("clr_done", done, 0);
        check("clr_mag", result_mag, 0);
        check("clr_sign", result_sign, 0);
        repeat (12) @(negedge clk);

        // clear and start together: start dropped
        a_sign = 0; a_mag = 4; b_sign = 0; b_mag = 4; op_code = 3'b000;
        start = 1'b1; clear = 1'b1;
        @(negedge clk);
        start = 1'b0; clear = 1'b0;
        check("clrstart_busy", busy, 0);
        repeat (3) @(negedge clk);

        // Asynchronous reset mid-operation
        issue("pre_rst", 1, 1, 1, 1, 3'b000, 1, 2, 1, 0, 0, 1); wait_idle("pre_rst");
`ifdef CALC_SEQ_DIV_EN
        issue("rst_op", 0, 200, 0, 7, 3'b011, 0, 0, 0, 0, 0, 0);
`else
        issue("rst_op", 0, 12, 0, 11, 3'b010, 0, 0, 0, 0, 0, 0);
`endif
        @(posedge clk);
        #3 reset_n = 1'b0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        check("arst_mag", result_mag, 0);
        check("arst_sign", result_sign, 0);
        check("arst_rem", remainder, 0);
        check("arst_err", error, 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        issue("post_rst", 0, 9, 1, 4, 3'b000, 1, 5, 0, 0, 0, 1); wait_idle("post_rst");

        repeat (5) @(negedge clk);
        check("sb_drain", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
